multicycle_step_sequencer: RTL and testbench

//   Multi-cycle control FSM for the core. Steps each instruction through fetch, decode, execute,

---
 rtl/multicycle_step_sequencer_pkg.sv | 36 +++
 rtl/multicycle_step_sequencer_mem_wait_timer.sv | 30 +++
 rtl/multicycle_step_sequencer.sv | 158 +++++++++++++++
 tb/tb_multicycle_step_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_step_sequencer_pkg.sv
// Shared control definitions for the multi-cycle core: sequencer states, fault codes,
// the memory timeout default and the decoder's ALU-source / write-back-source codes.
package multicycle_step_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5,
    ST_FAULT  = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    FAULT_NONE        = 2'b00,
    FAULT_MEM_TIMEOUT = 2'b01,
    FAULT_ILLEGAL     = 2'b10
  } fault_code_t;

  localparam int unsigned MEM_TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    ALU_SRC_RS2 = 2'd0,
    ALU_SRC_IMM = 2'd1,
    ALU_SRC_PC  = 2'd2
  } alu_src_t;

  typedef enum logic [1:0] {
    WB_SRC_ALU = 2'd0,
    WB_SRC_MEM = 2'd1,
    WB_SRC_PC4 = 2'd2,
    WB_SRC_IMM = 2'd3
  } wb_src_t;

endpackage

// File: rtl/multicycle_step_sequencer_mem_wait_timer.sv
// Memory-wait counter: cleared while no request is outstanding, counts unacked request
// cycles and flags expiry in the cycle that would reach LIMIT.
module mem_wait_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic inc,
  output logic expire
);

  localparam int unsigned W = (LIMIT < 2) ? 1 : $clog2(LIMIT);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  // Expiry is raised in the LIMIT-th unacked cycle so the FSM leaves on that edge.
  assign expire = inc && (count == W'(LIMIT - 1));

endmodule

// File: rtl/multicycle_step_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB over a single shared
// memory port, with halt at instruction boundaries and sticky fault reporting.
module multicycle_step_sequencer
  import multicycle_step_sequencer_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             should_read_mem,
  input  logic             should_write_mem,
  input  logic             should_write_reg,
  input  logic             instr_legal,
  input  logic             mem_ack,
  input  logic             halt_req,
  output logic             mem_req,
  output logic             mem_is_data,
  output logic             mem_we,
  output logic             instr_latch_en,
  output logic             reg_write_en,
  output logic             pc_write_en,
  output logic             halted,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [CNT_W-1:0] retired_count
);

  state_t      state, state_nxt;
  fault_code_t fault_q;

  logic mem_req_c, is_data_c, we_c, latch_c, reg_we_c, pc_we_c, halted_c, fault_c;
  logic set_timeout, set_illegal, instr_end;
  logic wait_inc, wait_clear, wait_expire;

  assign wait_inc   = ((state == ST_FETCH) || (state == ST_MEM)) && !mem_ack;
  assign wait_clear = !wait_inc;

  mem_wait_timer #(
    .LIMIT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (wait_clear),
    .inc     (wait_inc),
    .expire  (wait_expire)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_FETCH;
      fault_q       <= FAULT_NONE;
      retired_count <= '0;
    end else begin
      state <= state_nxt;
      if (set_timeout) begin
        fault_q <= FAULT_MEM_TIMEOUT;
      end else if (set_illegal) begin
        fault_q <= FAULT_ILLEGAL;
      end
      if (pc_we_c) begin
        retired_count <= retired_count + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    mem_req_c   = 1'b0;
    is_data_c   = 1'b0;
    we_c        = 1'b0;
    latch_c     = 1'b0;
    reg_we_c    = 1'b0;
    pc_we_c     = 1'b0;
    halted_c    = 1'b0;
    fault_c     = 1'b0;
    set_timeout = 1'b0;
    set_illegal = 1'b0;
    instr_end   = 1'b0;
    case (state)
      ST_FETCH: begin
        mem_req_c = 1'b1;
        if (mem_ack) begin
          latch_c   = 1'b1;
          state_nxt = ST_DECODE;
        end else if (wait_expire) begin
          set_timeout = 1'b1;
          state_nxt   = ST_FAULT;
        end
      end
      ST_DECODE: begin
        if (!instr_legal) begin
          set_illegal = 1'b1;
          state_nxt   = ST_FAULT;
        end else begin
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (should_read_mem || should_write_mem) begin
          state_nxt = ST_MEM;
        end else if (should_write_reg) begin
          state_nxt = ST_WB;
        end else begin
          instr_end = 1'b1;
        end
      end
      ST_MEM: begin
        mem_req_c = 1'b1;
        is_data_c = 1'b1;
        // A read flag takes precedence, so a read+write instruction never strobes mem_we.
        we_c      = should_write_mem && !should_read_mem;
        if (mem_ack) begin
          if (should_read_mem) begin
            state_nxt = ST_WB;
          end else begin
            instr_end = 1'b1;
          end
        end else if (wait_expire) begin
          set_timeout = 1'b1;
          state_nxt   = ST_FAULT;
        end
      end
      ST_WB: begin
        reg_we_c  = 1'b1;
        instr_end = 1'b1;
      end
      ST_HALT: begin
        halted_c = 1'b1;
        if (!halt_req) begin
          state_nxt = ST_FETCH;
        end
      end
      ST_FAULT: begin
        fault_c = 1'b1;
      end
      default: begin
        state_nxt = ST_FETCH;
      end
    endcase
    if (instr_end) begin
      pc_we_c   = 1'b1;
      state_nxt = halt_req ? ST_HALT : ST_FETCH;
    end
  end

  // Reset sits in FETCH, so outputs are masked by reset_n to drop mem_req asynchronously.
  assign mem_req        = mem_req_c & reset_n;
  assign mem_is_data    = is_data_c & reset_n;
  assign mem_we         = we_c      & reset_n;
  assign instr_latch_en = latch_c   & reset_n;
  assign reg_write_en   = reg_we_c  & reset_n;
  assign pc_write_en    = pc_we_c   & reset_n;
  assign halted         = halted_c  & reset_n;
  assign fault          = fault_c   & reset_n;
  assign fault_code     = fault_q;

endmodule

// File: tb/tb_multicycle_step_sequencer.sv
// Directed bench for multicycle_step_sequencer with hand-computed per-cycle output vectors.
module tb_multicycle_step_sequencer;

  localparam int unsigned CNT_W = 2;

  // obs bit order: mem_req, mem_is_data, mem_we, instr_latch_en, reg_write_en, pc_write_en, halted, fault
  localparam logic [7:0] O_IDLE       = 8'b0000_0000;
  localparam logic [7:0] O_FETCH      = 8'b1000_0000;
  localparam logic [7:0] O_FETCH_ACK  = 8'b1001_0000;
  localparam logic [7:0] O_MEM_RD     = 8'b1100_0000;
  localparam logic [7:0] O_MEM_WR     = 8'b1110_0000;
  localparam logic [7:0] O_MEM_WR_END = 8'b1110_0100;
  localparam logic [7:0] O_WB         = 8'b0000_1100;
  localparam logic [7:0] O_EXEC_END   = 8'b0000_0100;
  localparam logic [7:0] O_HALT       = 8'b0000_0010;
  localparam logic [7:0] O_FAULT      = 8'b0000_0001;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic should_read_mem = 1'b0, should_write_mem = 1'b0, should_write_reg = 1'b0;
  logic instr_legal = 1'b1, mem_ack = 1'b0, halt_req = 1'b0;
  logic mem_req, mem_is_data, mem_we, instr_latch_en, reg_write_en, pc_write_en, halted, fault;
  logic [1:0] fault_code;
  logic [CNT_W-1:0] retired_count;
  logic [7:0] obs;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign obs = {mem_req, mem_is_data, mem_we, instr_latch_en,
                reg_write_en, pc_write_en, halted, fault};

  multicycle_step_sequencer #(
    .MEM_TIMEOUT (4),
    .CNT_W       (CNT_W)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .should_read_mem  (should_read_mem),
    .should_write_mem (should_write_mem),
    .should_write_reg (should_write_reg),
    .instr_legal      (instr_legal),
    .mem_ack          (mem_ack),
    .halt_req         (halt_req),
    .mem_req          (mem_req),
    .mem_is_data      (mem_is_data),
    .mem_we           (mem_we),
    .instr_latch_en   (instr_latch_en),
    .reg_write_en     (reg_write_en),
    .pc_write_en      (pc_write_en),
    .halted           (halted),
    .fault            (fault),
    .fault_code       (fault_code),
    .retired_count    (retired_count)
  );

  // Leaves the bench 1 time unit into the first FETCH cycle after reset release.
  task automatic do_reset();
    reset_n = 1'b0;
    mem_ack = 1'b0;
    halt_req = 1'b0;
    should_read_mem = 1'b0;
    should_write_mem = 1'b0;
    should_write_reg = 1'b0;
    instr_legal = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    mem_ack = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    n_cmp++;
    if (obs !== O_IDLE) begin n_bad++; $display("FAIL reset_outputs got=%b want=%b", obs, O_IDLE); end
    n_cmp++;
    if (fault_code !== 2'b00) begin n_bad++; $display("FAIL reset_fault_code got=%b want=00", fault_code); end
    n_cmp++;
    if (retired_count !== 2'd0) begin n_bad++; $display("FAIL reset_retired got=%0d want=0", retired_count); end
    mem_ack = 1'b0;
  endtask

  task automatic test_addi();
    logic [7:0] exp_o [4];
    exp_o = '{O_FETCH_ACK, O_IDLE, O_IDLE, O_WB};
    do_reset();
    should_write_reg = 1'b1;
    for (int c = 0; c < 4; c++) begin
      mem_ack = (c == 0);
      @(negedge clk);
      n_cmp++;
      if (obs !== exp_o[c]) begin n_bad++; $display("FAIL addi_cycle%0d got=%b want=%b", c + 1, obs, exp_o[c]); end
      if (c == 3) begin
        n_cmp++;
        if (retired_count !== 2'd0) begin n_bad++; $display("FAIL addi_retired_before got=%0d want=0", retired_count); end
      end
      @(posedge clk);
      #1;
    end
    mem_ack = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (obs !== O_FETCH) begin n_bad++; $display("FAIL addi_next_fetch got=%b want=%b", obs, O_FETCH); end
    n_cmp++;
    if (retired_count !== 2'd1) begin n_bad++; $display("FAIL addi_retired_after got=%0d want=1", retired_count); end
  endtask

  task automatic test_load_delayed();
    logic [7:0] exp_o [8];
    logic       ack_v [8];
    exp_o = '{O_FETCH_ACK, O_IDLE, O_IDLE, O_MEM_RD, O_MEM_RD, O_MEM_RD, O_MEM_RD, O_WB};
    ack_v = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    should_read_mem = 1'b1;
    should_write_reg = 1'b1;
    for (int c = 0; c < 8; c++) begin
      mem_ack = ack_v[c];
      @(negedge clk);
      n_cmp++;
      if (obs !== exp_o[c]) begin n_bad++; $display("FAIL load_cycle%0d got=%b want=%b", c + 1, obs, exp_o[c]); end
      @(posedge clk);
      #1;
    end
    mem_ack = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (obs !== O_FETCH) begin n_bad++; $display("FAIL load_next_fetch got=%b want=%b", obs, O_FETCH); end
    n_cmp++;
    if (fault_code !== 2'b00) begin n_bad++; $display("FAIL load_no_fault got=%b want=00", fault_code); end
    n_cmp++;
    if (retired_count !== 2'd1) begin n_bad++; $display("FAIL load_retired got=%0d want=1", retired_count); end
  endtask

  task automatic test_store();
    logic [7:0] exp_o [5];
    logic       ack_v [5];
    exp_o = '{O_FETCH_ACK, O_IDLE, O_IDLE, O_MEM_WR, O_MEM_WR_END};
    ack_v = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    should_write_mem = 1'b1;
    for (int c = 0; c < 5; c++) begin
      mem_ack = ack_v[c];
      @(negedge clk);
      n_cmp++;
      if (obs !== exp_o[c]) begin n_bad++; $display("FAIL store_cycle%0d got=%b want=%b", c + 1, obs, exp_o[c]); end
      @(posedge clk);
      #1;
    end
    mem_ack = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (obs !== O_FETCH) begin n_bad++; $display("FAIL store_next_fetch got=%b want=%b", obs, O_FETCH); end
    n_cmp++;
    if (retired_count !== 2'd1) begin n_bad++; $display("FAIL store_retired got=%0d want=1", retired_count); end
  endtask

  task automatic test_read_write_both();
    logic [7:0] exp_o [5];
    exp_o = '{O_FETCH_ACK, O_IDLE, O_IDLE, O_MEM_RD, O_WB};
    do_reset();
    should_read_mem = 1'b1;
    should_write_mem = 1'b1;
    should_write_reg = 1'b1;
    for (int c = 0; c < 5; c++) begin
      mem_ack = (c == 0) || (c == 3);
      @(negedge clk);
      n_cmp++;
      if (obs !== exp_o[c]) begin n_bad++; $display("FAIL rdwr_cycle%0d got=%b want=%b", c + 1, obs, exp_o[c]); end
      @(posedge clk);
      #1;
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_o [3];
    exp_o = '{O_FETCH_ACK, O_IDLE, O_EXEC_END};
    do_reset();
    mem_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        n_cmp++;
        if (obs !== exp_o[c]) begin n_bad++; $display("FAIL fence%0d_cycle%0d got=%b want=%b", i, c + 1, obs, exp_o[c]); end
        if (c == 0) begin
          n_cmp++;
          if (retired_count !== 2'(i)) begin n_bad++; $display("FAIL fence%0d_retired got=%0d want=%0d", i, retired_count, i % 4); end
        end
        @(posedge clk);
        #1;
      end
    end
    mem_ack = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (retired_count !== 2'd1) begin n_bad++; $display("FAIL fence_wrap got=%0d want=1", retired_count); end
  endtask

  task automatic test_illegal();
    logic [7:0] exp_o [3];
    exp_o = '{O_FETCH_ACK, O_IDLE, O_FAULT};
    do_reset();
    instr_legal = 1'b0;
    for (int c = 0; c < 3; c++) begin
      mem_ack = (c == 0);
      @(negedge clk);
      n_cmp++;
      if (obs !== exp_o[c]) begin n_bad++; $display("FAIL illegal_cycle%0d got=%b want=%b", c + 1, obs, exp_o[c]); end
      @(posedge clk);
      #1;
    end
    for (int c = 0; c < 4; c++) begin
      mem_ack = c[0];
      halt_req = c[1];
      @(negedge clk);
      n_cmp++;
      if (obs !== O_FAULT) begin n_bad++; $display("FAIL illegal_sticky%0d got=%b want=%b", c, obs, O_FAULT); end
      n_cmp++;
      if (fault_code !== 2'b10) begin n_bad++; $display("FAIL illegal_code%0d got=%b want=10", c, fault_code); end
      @(posedge clk);
      #1;
    end
    mem_ack = 1'b0;
    halt_req = 1'b0;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (fault_code !== 2'b00) begin n_bad++; $display("FAIL illegal_reset_code got=%b want=00", fault_code); end
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs !== O_FETCH) begin n_bad++; $display("FAIL illegal_after_reset got=%b want=%b", obs, O_FETCH); end
  endtask

  task automatic test_timeout();
    logic [7:0] exp_o [5];
    exp_o = '{O_FETCH, O_FETCH, O_FETCH, O_FETCH, O_FAULT};
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== exp_o[c]) begin n_bad++; $display("FAIL timeout_cycle%0d got=%b want=%b", c + 1, obs, exp_o[c]); end
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (fault_code !== 2'b01) begin n_bad++; $display("FAIL timeout_code got=%b want=01", fault_code); end

    exp_o = '{O_FETCH, O_FETCH, O_FETCH, O_FETCH_ACK, O_IDLE};
    do_reset();
    for (int c = 0; c < 5; c++) begin
      mem_ack = (c == 3);
      @(negedge clk);
      n_cmp++;
      if (obs !== exp_o[c]) begin n_bad++; $display("FAIL ack_wins_cycle%0d got=%b want=%b", c + 1, obs, exp_o[c]); end
      @(posedge clk);
      #1;
    end
    mem_ack = 1'b0;
    n_cmp++;
    if (fault_code !== 2'b00) begin n_bad++; $display("FAIL ack_wins_code got=%b want=00", fault_code); end
  endtask

  task automatic test_halt();
    logic [7:0] exp_o [9];
    logic       ack_v [9];
    logic       hlt_v [9];
    exp_o = '{O_FETCH_ACK, O_IDLE, O_IDLE, O_MEM_RD, O_WB, O_HALT, O_HALT, O_HALT, O_FETCH};
    ack_v = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    hlt_v = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    should_read_mem = 1'b1;
    should_write_reg = 1'b1;
    for (int c = 0; c < 9; c++) begin
      mem_ack = ack_v[c];
      halt_req = hlt_v[c];
      @(negedge clk);
      n_cmp++;
      if (obs !== exp_o[c]) begin n_bad++; $display("FAIL halt_cycle%0d got=%b want=%b", c + 1, obs, exp_o[c]); end
      @(posedge clk);
      #1;
    end
    mem_ack = 1'b0;
    halt_req = 1'b0;
  endtask

  task automatic test_reset_mid_mem();
    do_reset();
    should_read_mem = 1'b1;
    should_write_reg = 1'b1;
    mem_ack = 1'b1;
    @(posedge clk);
    #1 mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (obs !== O_MEM_RD) begin n_bad++; $display("FAIL midmem_before got=%b want=%b", obs, O_MEM_RD); end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (mem_req !== 1'b0) begin n_bad++; $display("FAIL midmem_req_drop got=%b want=0", mem_req); end
    n_cmp++;
    if (obs !== O_IDLE) begin n_bad++; $display("FAIL midmem_outputs got=%b want=%b", obs, O_IDLE); end
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load_delayed();
    test_store();
    test_read_write_both();
    test_back_to_back();
    test_illegal();
    test_timeout();
    test_halt();
    test_reset_mid_mem();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
